// File: rtl/param_word_mem_pkg.sv
// Shared types and helpers for the parametrised word memory.
package mem_pkg;

  typedef enum logic {INIT, RUN} memState_e;

  localparam int DEFAULT_DATA_W = 32;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/param_word_mem_word_bank.sv
// DEPTH x DATA_W storage: one byte-enabled write port, one registered read port.
module mem_word_bank
  import mem_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic [DATA_W/8-1:0] wrBe,
  input  logic [IDX_W-1:0]    wrIdx,
  input  logic [DATA_W-1:0]   wrData,
  input  logic                rdEn,
  input  logic [IDX_W-1:0]    rdIdx,
  output logic [DATA_W-1:0]   rdData
);

  localparam int BW = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BW; i++) begin
      if (wrBe[i]) mem[wrIdx][8*i +: 8] <= wrData[8*i +: 8];
    end
    if (rdEn) rdData <= mem[rdIdx];
  end

endmodule

// File: rtl/param_word_mem.sv
// Parametrised word memory with clear walk, byte-lane writes and 1-cycle reads.
// Define PARAM_WORD_MEM_WRAP_EN to drop the out-of-range check (addresses wrap).
module param_word_mem
  import mem_pkg::*;
#(
  parameter int                 DATA_W   = DEFAULT_DATA_W,
  parameter int                 DEPTH    = 16,
  parameter int                 ADDR_W   = 32,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_busy
);

  localparam int BW    = DATA_W / 8;
  localparam int LSB   = clog2(BW);
  localparam int IDX_W = clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << LSB) - 1);

  memState_e state, nextState;
  logic [IDX_W-1:0] walkCnt;

  logic              accept, misaligned, outOfRange, addrErr;
  logic [IDX_W-1:0]  reqIdx, wrIdx;
  logic [BW-1:0]     wrBe;
  logic [DATA_W-1:0] wrData, bankRdata;
  logic              rdEn;
  logic              rspValidQ, rspErrQ, rspReadQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      INIT:    if (walkCnt == IDX_W'(DEPTH - 1)) nextState = RUN;
      RUN:     nextState = RUN;
      default: nextState = INIT;
    endcase
  end

  // Counter wraps back to 0 as the walk finishes; it is unused in RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              walkCnt <= '0;
    else if (state == INIT)  walkCnt <= walkCnt + 1'b1;
  end

  assign req_ready = (state == RUN);
  assign init_busy = (state == INIT);
  assign accept    = req_valid && req_ready;

  assign misaligned = |(req_addr & ALIGN_MASK);
`ifdef PARAM_WORD_MEM_WRAP_EN
  assign outOfRange = 1'b0;
`else
  assign outOfRange = |(req_addr >> (LSB + IDX_W));
`endif
  assign addrErr = misaligned || outOfRange;
  assign reqIdx  = req_addr[LSB+IDX_W-1:LSB];

  // The clear walk owns the write port while INIT; requests are not accepted then.
  always_comb begin
    wrIdx  = reqIdx;
    wrBe   = '0;
    wrData = req_wdata;
    if (state == INIT) begin
      wrIdx  = walkCnt;
      wrBe   = '1;
      wrData = INIT_VAL;
    end else if (accept && req_write && !addrErr) begin
      wrBe = req_be;
    end
  end

  assign rdEn = accept && !req_write && !addrErr;

  mem_word_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) uBank (
    .clk    (clk),
    .wrBe   (wrBe),
    .wrIdx  (wrIdx),
    .wrData (wrData),
    .rdEn   (rdEn),
    .rdIdx  (reqIdx),
    .rdData (bankRdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rspValidQ <= 1'b0;
      rspErrQ   <= 1'b0;
      rspReadQ  <= 1'b0;
    end else begin
      rspValidQ <= accept;
      rspErrQ   <= accept && addrErr;
      rspReadQ  <= rdEn;
    end
  end

  // Read data is gated so it reads as 0 for writes, errors and idle cycles.
  assign rsp_valid = rspValidQ;
  assign rsp_err   = rspErrQ;
  assign rsp_rdata = rspReadQ ? bankRdata : '0;

endmodule

// File: tb/tb_param_word_mem.sv
// Randomised bench for param_word_mem against a word-array reference model.
module tb_param_word_mem;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int BW     = DATA_W / 8;
  localparam logic [31:0] INIT_VAL = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mMem [DEPTH];
  int          mInitLeft = DEPTH;
  logic        expReady = 1'b0, expBusy = 1'b1, expValid = 1'b0, expErr = 1'b0;
  logic [31:0] expData = '0;

  param_word_mem #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .INIT_VAL (INIT_VAL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are all registered, so the falling edge sees a settled cycle.
  always @(negedge clk) begin
    check("req_ready", {31'b0, req_ready}, {31'b0, expReady});
    check("init_busy", {31'b0, init_busy}, {31'b0, expBusy});
    check("rsp_valid", {31'b0, rsp_valid}, {31'b0, expValid});
    check("rsp_err",   {31'b0, rsp_err},   {31'b0, expErr});
    check("rsp_rdata", rsp_rdata, expData);
  end

  // One clock edge of the specification's behaviour, applied to the inputs held at that edge.
  task automatic modelStep();
    logic bad;
    int   idx;
    if (mInitLeft > 0) begin
      mInitLeft--;
      if (mInitLeft == 0) for (int i = 0; i < DEPTH; i++) mMem[i] = INIT_VAL;
      expValid = 1'b0; expErr = 1'b0; expData = '0;
    end else if (req_valid) begin
      bad = (req_addr % BW) != 0;
`ifndef PARAM_WORD_MEM_WRAP_EN
      if (req_addr >= DEPTH * BW) bad = 1'b1;
`endif
      idx = int'((req_addr / BW) % DEPTH);
      if (!bad && req_write)
        for (int b = 0; b < BW; b++)
          if (req_be[b]) mMem[idx][8*b +: 8] = req_wdata[8*b +: 8];
      expValid = 1'b1;
      expErr   = bad;
      expData  = (!bad && !req_write) ? mMem[idx] : 32'h0;
    end else begin
      expValid = 1'b0; expErr = 1'b0; expData = '0;
    end
    expReady = (mInitLeft == 0);
    expBusy  = !expReady;
  endtask

  task automatic modelReset();
    mInitLeft = DEPTH;
    expReady = 1'b0; expBusy = 1'b1; expValid = 1'b0; expErr = 1'b0; expData = '0;
  endtask

  task automatic applyReset();
    reset = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic step(input logic v, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk);
    #1 modelStep();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    logic [31:0] a;
    int r;
    #1;
    check("reset_ready", {31'b0, req_ready}, 32'h0);
    check("reset_busy",  {31'b0, init_busy}, 32'h1);
    check("reset_valid", {31'b0, rsp_valid}, 32'h0);
    check("reset_rdata", rsp_rdata, 32'h0);
    applyReset();

    // Clear walk timing
    idle(15);
    check("walk_ready_c15", {31'b0, req_ready}, 32'h0);
    idle(1);
    check("walk_ready_c16", {31'b0, req_ready}, 32'h1);
    check("walk_busy_c16",  {31'b0, init_busy}, 32'h0);
    step(1, 0, 32'h3C, 0, 0);
    check("rd_3c_valid", {31'b0, rsp_valid}, 32'h1);
    check("rd_3c_data",  rsp_rdata, 32'h0);

    step(1, 1, 32'h08, 32'hDEADBEEF, 4'hF);
    check("wr_08_data", rsp_rdata, 32'h0);
    step(1, 0, 32'h08, 0, 0);
    check("rd_08_data", rsp_rdata, 32'hDEADBEEF);
    check("rd_08_err",  {31'b0, rsp_err}, 32'h0);

    step(1, 1, 32'h10, 32'h11223344, 4'hF);
    step(1, 1, 32'h10, 32'hAABBCCDD, 4'b0101);
    step(1, 0, 32'h10, 0, 0);
    check("rd_10_be", rsp_rdata, 32'h11BB33DD);

    step(1, 0, 32'h0A, 0, 0);
    check("misalign_err",  {31'b0, rsp_err}, 32'h1);
    check("misalign_data", rsp_rdata, 32'h0);

    step(1, 1, 32'h00, 32'h55667788, 4'hF);
    step(1, 1, 32'h40, 32'h99999999, 4'hF);
    step(1, 0, 32'h00, 0, 0);
`ifdef PARAM_WORD_MEM_WRAP_EN
    check("wrap_word0", rsp_rdata, 32'h99999999);
`else
    check("oor_word0", rsp_rdata, 32'h55667788);
`endif

    step(1, 1, 32'h04, 32'hCAFEF00D, 4'h0);
    step(1, 0, 32'h04, 0, 0);
    check("be0_noop", rsp_rdata, 32'h0);

    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, DEPTH - 1)) * BW;
      if (r == 8)      a = a + 32'($urandom_range(1, BW - 1));
      else if (r == 9) a = a + (32'($urandom_range(1, 255)) << 6);
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end

    // Request held during the walk is ignored until ready rises
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h08;
    applyReset();
    for (int i = 0; i < 16; i++) step(1, 0, 32'h08, 0, 0);
    check("hold_ready",   {31'b0, req_ready}, 32'h1);
    check("hold_novalid", {31'b0, rsp_valid}, 32'h0);
    step(1, 0, 32'h08, 0, 0);
    check("hold_first_rsp", {31'b0, rsp_valid}, 32'h1);
    check("hold_first_data", rsp_rdata, 32'h0);

    // Reset during a read response
    step(1, 1, 32'h20, 32'h12345678, 4'hF);
    step(1, 0, 32'h20, 0, 0);
    check("mid_valid", {31'b0, rsp_valid}, 32'h1);
    check("mid_data",  rsp_rdata, 32'h12345678);
    #2 reset = 1'b0;
    modelReset();
    #1;
    check("mid_drop_valid", {31'b0, rsp_valid}, 32'h0);
    check("mid_drop_data",  rsp_rdata, 32'h0);
    req_valid = 1'b0;
    applyReset();
    idle(16);
    step(1, 0, 32'h20, 0, 0);
    check("post_reset_data", rsp_rdata, INIT_VAL);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_word_mem.md
Name: param_word_mem

Overview:
- Parametrised successor to the fixed 16×32 register-array memories. DEPTH and DATA_W are configurable.
- Adds byte-lane writes, a registered read with a valid/ready request handshake, alignment and range error reporting, and a post-reset clear sequencer.
- Used as the data memory, and as instruction store, behind the VLIW load/store and fetch units.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 16, number of words; must be a power of 2, at least 2.
- ADDR_W, 32, byte-address width.
- INIT_VAL, 0, value written to every word during the clear walk.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid  out  1  response pulse, one per accepted request.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  request was misaligned or out of range.
- init_busy  out  1  clear walk in progress.

Behaviour:
- Derived constants:
  - BW = DATA_W/8.
  - LSB = log2(BW).
  - IDX_W = log2(DEPTH).
  - Word index = req_addr[LSB+IDX_W-1:LSB].
- Reset (reset low, asynchronous):
  - State = INIT, walk counter = 0.
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, init_busy = 1.
  - Memory contents are undefined until the walk completes.
- State INIT:
  - Each cycle writes INIT_VAL to word[counter] and increments counter.
  - After word DEPTH-1 is written, moves to RUN. The walk takes exactly DEPTH cycles after reset release.
  - req_ready = 0; requests are ignored, not queued.
- State RUN:
  - req_ready = 1 every cycle.
  - A request is accepted when req_valid && req_ready. One request per cycle.
- Error check on an accepted request:
  - misaligned: req_addr[LSB-1:0] != 0.
  - out of range: any req_addr bit at or above LSB+IDX_W is set.
  - Either condition gives error: no memory update; rsp_err = 1 and rsp_rdata = 0 on the next cycle.
- Accepted write, no error:
  - At the accept edge, each byte lane with req_be[i] = 1 is updated; other lanes are unchanged.
  - req_be = 0 is legal and leaves memory unchanged.
  - Response the next cycle: rsp_valid = 1, rsp_err = 0, rsp_rdata = 0.
- Accepted read, no error:
  - rsp_rdata = word[index] as it stands after the accept edge.
  - Read latency is 1 cycle: rsp_valid is high the cycle after acceptance.
- Back-to-back requests:
  - A read accepted the cycle after a write to the same word returns the new data.
  - Consecutive accepted requests produce rsp_valid high on consecutive cycles.
- Response outputs when idle:
  - rsp_valid is low in every cycle not following an acceptance.
  - rsp_rdata and rsp_err return to 0 when rsp_valid is low.
- Reset asserted mid-walk or mid-transaction:
  - Any pending response is dropped (rsp_valid = 0 immediately).
  - The walk restarts from 0 after release.

Optional Feature:
- Macro: PARAM_WORD_MEM_WRAP_EN.
- When defined:
  - The out-of-range check is removed; the upper address bits are ignored, so addresses wrap modulo DEPTH*BW.
  - Misalignment is still an error.
- When undefined: out-of-range addresses produce rsp_err as described in Behaviour.

Decomposition:
- Package mem_pkg:
  - State enum {INIT, RUN}.
  - Function clog2.
  - Constant DEFAULT_DATA_W = 32.
- One sub-module, mem_word_bank:
  - The DEPTH×DATA_W storage array.
  - Per-byte write enables, one write port and one synchronous read port.
  - param_word_mem holds the FSM, walk counter, address checks and response registers.

Test Plan (DEPTH=16, DATA_W=32):
- Clear walk: release reset with INIT_VAL = 0 → init_busy high for 16 cycles, req_ready rises on cycle 17; reading addr 0x3C returns 0x00000000 one cycle later.
- Word write then read: write 0xDEADBEEF to 0x08 with be = 4'hF, then read 0x08 on the next cycle → rsp_rdata = 0xDEADBEEF, rsp_err = 0, one rsp_valid per request.
- Byte enables: word 0x10 holds 0x11223344; write 0xAABBCCDD with be = 4'b0101 → read returns 0x11BB33DD.
- Errors: read 0x0A → rsp_err = 1, rsp_rdata = 0. Write 0x40 → rsp_err = 1 and word 0 unchanged. With PARAM_WORD_MEM_WRAP_EN, write to 0x40 lands in word 0 with rsp_err = 0.
- Handshake in INIT: req_valid held high during the walk → no rsp_valid; the first response appears exactly one cycle after req_ready rises.
- Reset mid-operation: assert reset during a read's response cycle → rsp_valid drops immediately; after release the walk reruns and previously written data reads back as INIT_VAL.
